// File: rtl/sl_pkg.sv
// Shared definitions for the serial-line word receiver: register field
// positions, reset config, FSM states and small field helpers.
package sl_pkg;

  // Status register bit positions
  localparam int ST_LEN_ERR = 0;
  localparam int ST_READY   = 3;
  localparam int ST_PAR_ERR = 4;
  localparam int ST_LVL_ERR = 5;

  // Config register field positions
  localparam int CFG_PCE     = 0;
  localparam int CFG_LEN_LSB = 1;
  localparam int CFG_LEN_MSB = 6;

  localparam logic [15:0] CFG_RESET = 16'h0010;  // LEN=8, PCE=0
  localparam logic [5:0]  MAX_LEN   = 6'd32;
  localparam logic [5:0]  CNT_SAT   = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIT0 = 3'd1,
    S_BIT1 = 3'd2,
    S_STOP = 3'd3,
    S_LVL  = 3'd4
  } sl_state_e;

  // Word length taken from config, clamped to the data path width
  function automatic logic [5:0] eff_len(input logic [15:0] cfg);
    logic [5:0] l;
    l = cfg[CFG_LEN_MSB:CFG_LEN_LSB];
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  // Mask with the low 'len' bits set
  function automatic logic [31:0] len_mask(input logic [5:0] len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (i < int'(len)) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/sl_receiver_if.sv
// Host register interface of the serial-line receiver.
interface sl_receiver_if;
  logic        wr_enable;
  logic [15:0] wr_config_w;
  logic [15:0] r_config_w;
  logic [31:0] data_w;
  logic [15:0] status_w;
  logic        word_picked;
  logic        data_status_changed;

  modport master (
    output wr_enable, wr_config_w, word_picked,
    input  r_config_w, data_w, status_w, data_status_changed
  );

  modport slave (
    input  wr_enable, wr_config_w, word_picked,
    output r_config_w, data_w, status_w, data_status_changed
  );
endinterface

// File: rtl/sl_line_sync.sv
// Multi-stage synchronizer for a bundle of asynchronous, idle-high lines.
module sl_line_sync #(
  parameter int NUM_LANES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] line_a,
  output logic [NUM_LANES-1:0] line_s
);

  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q, sync_d;

  // Shift each lane one stage deeper per clock
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = line_a;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // Reset to the idle-high level so no false pulse is seen after reset
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign line_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sl_receiver.sv
// Two-wire serial-line word receiver: self-timed bit capture, frame
// evaluation at end-of-word, config/status/data registers for the host.
module sl_receiver
  import sl_pkg::*;
#(
  parameter int LEVEL_TIMEOUT = 128,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_line_zeroes_a,
  input  logic serial_line_ones_a,
  sl_receiver_if.slave host
);

  localparam int TMR_W = $clog2(LEVEL_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LEVEL_TIMEOUT - 1);

  logic [1:0] line_s;
  logic       z, o;

  sl_line_sync #(
    .NUM_LANES   (2),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_a ({serial_line_ones_a, serial_line_zeroes_a}),
    .line_s (line_s)
  );

  assign z = line_s[0];
  assign o = line_s[1];

  sl_state_e        state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [32:0]      rx_q, rx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      cfg_q, cfg_d;
  logic [31:0]      data_q, data_d;
  logic [15:0]      status_q, status_d;
  logic             dsc_q, dsc_d;

  logic       timed;
  logic       store;
  logic       bit_v;
  logic       eval;
  logic [5:0] len;
  logic       perr;

  assign len   = eff_len(cfg_q);
  assign perr  = ~par_q;  // odd parity over data+parity is required
  assign timed = (state_q == S_BIT0) || (state_q == S_BIT1) || (state_q == S_STOP);

  // Next state, bit capture, frame evaluation and host register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    rx_d     = rx_q;
    tmr_d    = '0;
    cfg_d    = cfg_q;
    data_d   = data_q;
    status_d = status_q;
    store    = 1'b0;
    bit_v    = 1'b0;
    eval     = 1'b0;

    if (host.wr_enable) cfg_d = host.wr_config_w;

    // Acknowledge clears ready; a frame accepted this cycle sets it again below
    if (host.word_picked) status_d[ST_READY] = 1'b0;

    if (timed) tmr_d = tmr_q + 1'b1;

    if (timed && (tmr_q == TMR_LAST)) begin
      // A line stuck low: drop the partial frame, keep the last good word
      state_d              = S_LVL;
      cnt_d                = '0;
      par_d                = 1'b0;
      status_d[ST_LVL_ERR] = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!z && !o)  state_d = S_STOP;
          else if (!z)   state_d = S_BIT0;
          else if (!o)   state_d = S_BIT1;
        end
        S_BIT0: begin
          if (z) begin
            store   = 1'b1;
            bit_v   = 1'b0;
            state_d = S_IDLE;
          end else if (!o) begin
            state_d = S_STOP;
          end
        end
        S_BIT1: begin
          if (o) begin
            store   = 1'b1;
            bit_v   = 1'b1;
            state_d = S_IDLE;
          end else if (!z) begin
            state_d = S_STOP;
          end
        end
        S_STOP:  if (z && o) state_d = S_IDLE;
        S_LVL:   if (z && o) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      eval = (state_d == S_STOP) && (state_q != S_STOP);
    end

    if (store) begin
      if (cnt_q <= MAX_LEN) rx_d[cnt_q] = bit_v;
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
      if (bit_v) par_d = ~par_q;
    end

    // Frame evaluation on end-of-word; last received bit is the parity bit
    if (eval) begin
      if (cnt_q == 6'd0) begin
        // empty frame: nothing to report
      end else if ({1'b0, cnt_q} != ({1'b0, len} + 7'd1)) begin
        status_d[ST_LEN_ERR] = 1'b1;
        status_d[ST_PAR_ERR] = 1'b0;
        status_d[ST_LVL_ERR] = 1'b0;
      end else if (cfg_q[CFG_PCE] && perr) begin
        status_d[ST_LEN_ERR] = 1'b0;
        status_d[ST_PAR_ERR] = 1'b1;
        status_d[ST_LVL_ERR] = 1'b0;
      end else begin
        data_d               = rx_q[31:0] & len_mask(len);
        status_d[ST_READY]   = 1'b1;
        status_d[ST_LEN_ERR] = 1'b0;
        status_d[ST_LVL_ERR] = 1'b0;
        status_d[ST_PAR_ERR] = perr;
      end
      cnt_d = '0;
      par_d = 1'b0;
    end

    dsc_d = (data_d != data_q) || (status_d != status_q);
  end

  // State and register flops; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      rx_q     <= '0;
      tmr_q    <= '0;
      cfg_q    <= CFG_RESET;
      data_q   <= '0;
      status_q <= '0;
      dsc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      rx_q     <= rx_d;
      tmr_q    <= tmr_d;
      cfg_q    <= cfg_d;
      data_q   <= data_d;
      status_q <= status_d;
      dsc_q    <= dsc_d;
    end
  end

  assign host.r_config_w          = cfg_q;
  assign host.data_w              = data_q;
  assign host.status_w            = status_q;
  assign host.data_status_changed = dsc_q;

endmodule

// File: tb/tb_sl_receiver.sv
// Self-checking bench for sl_receiver: directed cases plus random frames
// compared against a frame-level reference model.
module tb_sl_receiver;

  logic clk = 1'b0;
  logic rst;
  logic zl, ol;

  sl_receiver_if bus();

  sl_receiver #(
    .LEVEL_TIMEOUT (128),
    .SYNC_STAGES   (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .serial_line_zeroes_a (zl),
    .serial_line_ones_a   (ol),
    .host                 (bus)
  );

  always #5 clk = ~clk;

  int n_chk   = 0;
  int n_err   = 0;
  int dsc_cnt = 0;

  logic [15:0] m_cfg;
  logic [15:0] m_status;
  logic [31:0] m_data;

  // Count change pulses, sampled away from the active edge
  always @(negedge clk) if (bus.data_status_changed === 1'b1) dsc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive bits[0..n-1] LSB first, then the both-low end marker
  task automatic send_frame(input logic [63:0] bits, input int n, input int pw);
    for (int i = 0; i < n; i++) begin
      if (bits[i]) ol = 1'b0;
      else         zl = 1'b0;
      tick(pw);
      zl = 1'b1; ol = 1'b1;
      tick(pw);
    end
    zl = 1'b0; ol = 1'b0;
    tick(pw);
    zl = 1'b1; ol = 1'b1;
    tick(pw);
    tick(4);
  endtask

  function automatic int model_len();
    int l;
    l = int'(m_cfg[6:1]);
    return (l > 32) ? 32 : l;
  endfunction

  // Data word plus parity bit at index len; good => odd total of ones
  function automatic logic [63:0] make_word(input logic [31:0] d, input int len, input bit good);
    logic [63:0] b;
    int ones;
    b = 64'(d) & ((64'd1 << len) - 64'd1);
    ones = 0;
    for (int i = 0; i < len; i++) ones += int'(b[i]);
    b[len] = ((ones % 2) == 0) ? good : !good;
    return b;
  endfunction

  // Frame-level reference: what the host should see after end-of-word
  task automatic model_frame(input logic [63:0] bits, input int n);
    int len, ones;
    bit pe;
    len = model_len();
    if (n == 0) return;
    if (n != len + 1) begin
      m_status = (m_status & ~16'h0031) | 16'h0001;
      return;
    end
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(bits[i]);
    pe = ((ones % 2) == 0);
    if (m_cfg[0] && pe) begin
      m_status = (m_status & ~16'h0031) | 16'h0010;
    end else begin
      m_data   = 32'(bits & ((64'd1 << len) - 64'd1));
      m_status = (m_status & ~16'h0031) | 16'h0008 | (pe ? 16'h0010 : 16'h0000);
    end
  endtask

  task automatic do_frame(input string tag, input logic [63:0] bits, input int n, input int pw);
    logic [31:0] od;
    logic [15:0] os;
    int base;
    od = m_data; os = m_status; base = dsc_cnt;
    model_frame(bits, n);
    send_frame(bits, n, pw);
    chk({tag, "_data"}, bus.data_w, m_data);
    chk({tag, "_status"}, {16'h0, bus.status_w}, {16'h0, m_status});
    chk({tag, "_pulses"}, 32'(dsc_cnt - base), ((od != m_data) || (os != m_status)) ? 32'd1 : 32'd0);
  endtask

  task automatic write_cfg(input logic [15:0] v);
    bus.wr_enable = 1'b1; bus.wr_config_w = v;
    tick(1);
    bus.wr_enable = 1'b0;
    m_cfg = v;
    tick(1);
    chk("cfg_rb", {16'h0, bus.r_config_w}, {16'h0, v});
    chk("cfg_status_kept", {16'h0, bus.status_w}, {16'h0, m_status});
  endtask

  task automatic ack();
    int base;
    logic [15:0] os;
    base = dsc_cnt; os = m_status;
    bus.word_picked = 1'b1;
    tick(1);
    bus.word_picked = 1'b0;
    tick(3);
    m_status[3] = 1'b0;
    chk("ack_status", {16'h0, bus.status_w}, {16'h0, m_status});
    chk("ack_data", bus.data_w, m_data);
    chk("ack_pulses", 32'(dsc_cnt - base), (os != m_status) ? 32'd1 : 32'd0);
  endtask

  task automatic level_err(input bit on_ones);
    if (on_ones) ol = 1'b0;
    else         zl = 1'b0;
    tick(700);
    chk("lvl_bit_held", {31'h0, bus.status_w[5]}, 32'd1);
    zl = 1'b1; ol = 1'b1;
    tick(10);
    m_status = m_status | 16'h0020;
    chk("lvl_status", {16'h0, bus.status_w}, {16'h0, m_status});
    chk("lvl_data", bus.data_w, m_data);
  endtask

  initial begin
    logic [63:0] b;
    int pw, len, n, mode;
    logic [15:0] cv;

    rst = 1'b1; zl = 1'b1; ol = 1'b1;
    bus.wr_enable = 1'b0; bus.wr_config_w = '0; bus.word_picked = 1'b0;
    m_cfg = 16'h0010; m_data = '0; m_status = '0;
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_cfg", {16'h0, bus.r_config_w}, 32'h0010);
    chk("rst_data", bus.data_w, 32'h0);
    chk("rst_status", {16'h0, bus.status_w}, 32'h0);
    chk("rst_dsc", {31'h0, bus.data_status_changed}, 32'h0);

    // Nominal word, then acknowledge
    write_cfg(16'h0011);
    do_frame("nominal", make_word(32'hA5, 8, 1'b1), 9, 16);
    chk("nominal_const_data", bus.data_w, 32'h0000_00A5);
    chk("nominal_const_status", {16'h0, bus.status_w}, 32'h0008);
    ack();

    // Parity error with checking enabled keeps the old word
    do_frame("par_bad", make_word(32'h3C, 8, 1'b0), 9, 16);
    chk("par_bad_const", {16'h0, bus.status_w}, 32'h0010);
    do_frame("good_a", make_word(32'h5A, 8, 1'b1), 9, 16);
    do_frame("par_bad2", make_word(32'h3C, 8, 1'b0), 9, 16);
    chk("par_bad2_const", {16'h0, bus.status_w}, 32'h0018);
    do_frame("good_b", make_word(32'hC3, 8, 1'b1), 9, 16);

    // Nominal and length error across pulse widths
    for (int k = 0; k < 3; k++) begin
      pw = 8 << k;
      do_frame("nom_pw", make_word(32'($urandom) & 32'hFF, 8, 1'b1), 9, pw);
      do_frame("len_err", make_word(32'($urandom), 9, 1'b1), 10, pw);
      chk("len_err_const", {16'h0, bus.status_w}, 32'h0009);
      do_frame("len_recover", make_word(32'($urandom) & 32'hFF, 8, 1'b1), 9, pw);
    end

    // Parity error reported but word accepted when checking is off
    write_cfg(16'h0040);
    do_frame("pce0", make_word(32'hDEADBEEF, 32, 1'b0), 33, 8);
    chk("pce0_const_data", bus.data_w, 32'hDEADBEEF);
    chk("pce0_const_status", {16'h0, bus.status_w}, 32'h0018);

    // Stuck-low lines
    write_cfg(16'h0011);
    level_err(1'b0);
    level_err(1'b1);
    do_frame("after_lvl", make_word(32'h96, 8, 1'b1), 9, 16);
    chk("after_lvl_const", {16'h0, bus.status_w}, 32'h0008);

    // End marker with no bits is ignored
    do_frame("empty", 64'h0, 0, 8);

    // Random frames against the model
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 40);
      cv  = {7'($urandom), 6'(len), 1'($urandom)};
      cv[15:7] = 9'($urandom);
      write_cfg(cv);
      len  = model_len();
      pw   = 8 << $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      if (mode == 2) begin
        n = $urandom_range(1, 40);
        if (n == len + 1) n = len + 2;
        b = {32'($urandom), 32'($urandom)};
      end else begin
        n = len + 1;
        b = make_word(32'($urandom), len, mode != 1);
      end
      do_frame("rnd", b, n, pw);
      if (mode == 3) ack();
    end

    // Reset in the middle of a frame drops the partial bits
    write_cfg(16'h0011);
    for (int i = 0; i < 3; i++) begin
      zl = 1'b0; tick(8); zl = 1'b1; tick(8);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_cfg = 16'h0010; m_data = '0; m_status = '0;
    tick(4);
    chk("midrst_status", {16'h0, bus.status_w}, 32'h0);
    chk("midrst_cfg", {16'h0, bus.r_config_w}, 32'h0010);
    do_frame("midrst_good", make_word(32'h81, 8, 1'b0), 9, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sl_receiver.md
Name: sl_receiver

Overview:
- Two-wire serial-line (SL) word receiver with a 16-bit config register and 16-bit status register, plus a 32-bit data output.
- Line encoding:
  - Each bit is a low pulse on one line; the other line stays high.
  - A low on serial_line_zeroes_a is a '0'; a low on serial_line_ones_a is a '1'.
  - Both lines low together marks end of word.
- Bit rate is not configured; the receiver self-times on pulse edges.
- Sits between the SL pins and a host register interface.

Parameters:
- LEVEL_TIMEOUT, 128: number of clk cycles a line may stay low before a level error is flagged.
- SYNC_STAGES, 2: synchronizer depth on the asynchronous line inputs.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- serial_line_zeroes_a  in  1  async line; low pulse = '0' bit; idle high
- serial_line_ones_a  in  1  async line; low pulse = '1' bit; idle high
- wr_enable  in  1  load wr_config_w into the config register this cycle
- wr_config_w  in  16  config write data
- r_config_w  out  16  config register readback
- data_w  out  32  last accepted word, LSB = first received bit, unused MSBs = 0
- status_w  out  16  status register
- word_picked  in  1  host acknowledge; clears status[3]
- data_status_changed  out  1  one-cycle pulse whenever data_w or status_w changed on the previous edge

Behaviour:
- Reset values: config = 16'h0010 (length 8, PCE 0); data_w = 0; status_w = 0; data_status_changed = 0; FSM in IDLE; bit counter = 0.
- Config register fields:
  - [0] PCE, parity check enable.
  - [6:1] LEN, number of data bits, legal 1..32; values above 32 are treated as 32.
  - [15:7] stored and read back, otherwise ignored.
  - Writing config does not touch data or status.
- Status register fields:
  - [0] length error
  - [3] word ready
  - [4] parity error
  - [5] level error
  - All other bits read 0.
- Line inputs pass through SYNC_STAGES flops; the FSM uses only the synchronized values z and o.
- FSM states:
  - IDLE: z=0,o=1 -> BIT0; z=1,o=0 -> BIT1; both 0 -> STOP.
  - BIT0: z returns 1 -> store '0' at index cnt, cnt++, go to IDLE; o falls -> STOP.
  - BIT1: mirror of BIT0; a stored '1' also toggles the ones-parity accumulator.
  - STOP: evaluate the frame once on entry; leave to IDLE when both lines are high.
  - LVL: wait until both lines are high, then go to IDLE.
- Low timer: counts cycles in BIT0, BIT1 and STOP. Reaching LEVEL_TIMEOUT forces LVL, sets status[5], clears cnt and parity, and leaves data and status[3] unchanged.
- The bit counter saturates at 63. Stored bits beyond index 32 are discarded.
- Frame evaluation at STOP entry (the last received bit is the parity bit):
  - cnt==0: ignore the frame.
  - cnt != LEN+1: status[0]=1, status[4]=0, status[5]=0; data and status[3] unchanged.
  - Otherwise the parity error condition is an even total count of '1's over data+parity (odd parity required).
    - PCE=1 and parity error: status = {[4]=1, [0]=0, [5]=0}; data unchanged; [3] unchanged.
    - Otherwise: data_w = received LEN bits, zero-extended; status[3]=1; status[0]=0, status[5]=0; status[4] = parity error (reported even when PCE=0).
  - After evaluation, cnt and parity clear.
- word_picked sampled high clears status[3] on the next edge. If a frame is accepted in the same cycle, the set wins.
- Reset mid-frame aborts the frame completely.

Decomposition:
- Shared package sl_pkg:
  - status bit indices (ST_LEN_ERR=0, ST_READY=3, ST_PAR_ERR=4, ST_LVL_ERR=5);
  - config field positions (CFG_PCE=0, CFG_LEN=6:1);
  - reset config value 16'h0010;
  - FSM state enum.
- One sub-module, sl_line_sync: parameterized synchronizer for both lines. Everything else stays in sl_receiver.

Test Plan:
- Nominal word: config LEN=8, PCE=1; send 0xA5 LSB first with 16-clk low pulses, 32-clk bit period, correct odd parity, stop = both low for 16 clks -> data_w=0x000000A5, status=16'h0008, one data_status_changed pulse.
- Parity error with PCE=1: accept a word, then send 0x3C with wrong parity -> data_w keeps the previous word, status=16'h0018. Next good word -> status=16'h0008.
- Parity error with PCE=0: LEN=32, send 0xDEADBEEF with wrong parity -> data_w=0xDEADBEEF, status=16'h0018.
- Length error: LEN=8, send a 10-bit word -> data_w unchanged, status=16'h0009. Next good 8-bit word -> status=16'h0008.
- Level error: hold the zeroes line low for 700 clks -> status[5]=1 before release. Repeat on the ones line -> status[5]=1. A following good word -> status=16'h0008 with correct data.
- Acknowledge: after an accepted word, pulse word_picked for 1 clk -> status=16'h0000, data_w unchanged. Repeat the nominal and length-error cases at 8-, 16- and 32-clk pulse widths.
